// File: rtl/sw_datapath.sv
// sw_datapath: multi-cycle store-word engine (register read, address ALU, memory write).
// Optional macro SW_BYPASS_EN forwards a same-cycle host register write into the READ capture.
module sw_datapath #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RF_AW-1:0]  rs,
  input  logic [RF_AW-1:0]  rt,
  input  logic [7:0]        offset,
  input  logic [3:0]        ALU_Sel,
  input  logic              rf_we,
  input  logic [RF_AW-1:0]  rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done,
  output logic              MemWrite,
  output logic [DATA_W-1:0] ALUout,
  output logic [DATA_W-1:0] W_RD1,
  output logic [DATA_W-1:0] W_RD2
);

  // Handshake: start is sampled only in IDLE (never queued); busy is high in every
  // other state; done is a one-cycle pulse in DONE, after which IDLE accepts again.
  typedef enum logic [2:0] {S_IDLE, S_READ, S_ADDR, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [RF_AW-1:0]    rs_q, rs_d, rt_q, rt_d;
  logic [7:0]          off_q, off_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, alu_q, alu_d;
  logic [DATA_W-1:0]   rf_rd1, rf_rd2, off_sext, alu_res;
  logic                fwd_rs, fwd_rt;

  logic [DATA_W-1:0]   rf  [2**RF_AW];
  logic [DATA_W-1:0]   mem [2**MEM_AW];

`ifdef SW_BYPASS_EN
  assign fwd_rs = rf_we && (rf_waddr == rs_q) && (rs_q != '0);
  assign fwd_rt = rf_we && (rf_waddr == rt_q) && (rt_q != '0);
`else
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif

  // R0 is hardwired to zero on the read side; its storage is never written.
  assign rf_rd1 = fwd_rs ? rf_wdata : ((rs_q == '0) ? '0 : rf[rs_q]);
  assign rf_rd2 = fwd_rt ? rf_wdata : ((rt_q == '0) ? '0 : rf[rt_q]);

  assign off_sext = {{(DATA_W-8){off_q[7]}}, off_q};
  assign alu_res  = (sel_q == 4'b0001) ? (rd1_q - off_sext) : (rd1_q + off_sext);

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    off_d    = off_q;
    sel_d    = sel_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    alu_d    = alu_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    MemWrite = (state_q == S_WRITE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rs_d    = rs;
          rt_d    = rt;
          off_d   = offset;
          sel_d   = ALU_Sel;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd1_d   = rf_rd1;
        rd2_d   = rf_rd2;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        alu_d   = alu_res;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      off_q   <= '0;
      sel_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      alu_q   <= alu_d;
    end
  end

  // Storage arrays are not reset; an async reset before the WRITE edge leaves
  // state_q in IDLE, so the pending store is dropped.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != '0)) rf[rf_waddr] <= rf_wdata;
    if (state_q == S_WRITE) mem[alu_q[MEM_AW-1:0]] <= rd2_q;
  end

  assign dbg_data = mem[dbg_addr];
  assign ALUout   = alu_q;
  assign W_RD1    = rd1_q;
  assign W_RD2    = rd2_q;

endmodule

// File: tb/tb_sw_datapath.sv
// Self-checking bench for sw_datapath: directed scenarios plus randomized store ops.
module tb_sw_datapath;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0]   rs = '0, rt = '0, rf_waddr = '0;
  logic [7:0]   offset = '0, dbg_addr = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         rf_we = 1'b0;
  logic [W-1:0] rf_wdata = '0;
  logic [W-1:0] dbg_data, ALUout, W_RD1, W_RD2;
  logic         busy, done, MemWrite;

  sw_datapath dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs(rs), .rt(rt), .offset(offset),
    .ALU_Sel(ALU_Sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done),
    .MemWrite(MemWrite), .ALUout(ALUout), .W_RD1(W_RD1), .W_RD2(W_RD2)
  );

  always #5 clk = ~clk;

  int           n_tests = 0, n_fail = 0, done_total = 0, mw_cnt = 0;
  bit           done_prev = 1'b0;
  logic [W-1:0] exp_addr_q[$], exp_base_q[$], exp_data_q[$];
  logic [W-1:0] rf_m [32];
  logic [W-1:0] mem_m [256];
  bit           mem_v [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: effective address and store data straight from the op definition.
  task automatic model_op(input logic [4:0] a_rs, input logic [4:0] a_rt,
                          input logic [7:0] off, input logic [3:0] sel,
                          output logic [W-1:0] addr);
    int base, s, r;
    base = int'(rf_m[a_rs]);
    s    = off[7] ? int'(off) - 256 : int'(off);
    r    = (sel == 4'd1) ? base - s : base + s;
    addr = r[15:0];
    exp_addr_q.push_back(addr);
    exp_base_q.push_back(rf_m[a_rs]);
    exp_data_q.push_back(rf_m[a_rt]);
    mem_m[addr[7:0]] = rf_m[a_rt];
    mem_v[addr[7:0]] = 1'b1;
  endtask

  task automatic start_op(input logic [4:0] a_rs, input logic [4:0] a_rt,
                          input logic [7:0] off, input logic [3:0] sel);
    @(posedge clk); #1;
    start = 1'b1; rs = a_rs; rt = a_rt; offset = off; ALU_Sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
    rs = 5'($urandom); rt = 5'($urandom); offset = 8'($urandom); ALU_Sel = 4'($urandom);
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(posedge clk); #1;
    rf_we = 1'b0;
    if (a != 5'd0) rf_m[a] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wait_idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_mem(input logic [7:0] a);
    dbg_addr = a;
    #1;
    check($sformatf("mem[0x%02h]", a), dbg_data, mem_m[a]);
  endtask

  // Monitor: pops the scoreboard on every done pulse, independent of the driver.
  always @(negedge clk) begin
    if (!rst_n) begin
      mw_cnt    = 0;
      done_prev = 1'b0;
    end else begin
      if (MemWrite) mw_cnt++;
      if (done) begin
        done_total++;
        check("done_single_cycle", {31'b0, done_prev}, 32'd0);
        check("memwrite_cycles", mw_cnt, 1);
        mw_cnt = 0;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_done", 0, 1);
        end else begin
          check("aluout", ALUout, exp_addr_q.pop_front());
          check("w_rd1", W_RD1, exp_base_q.pop_front());
          check("w_rd2", W_RD2, exp_data_q.pop_front());
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int           n, d0;
    logic [4:0]   r_rs, r_rt;
    logic [7:0]   r_off;
    logic [3:0]   r_sel;

    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    for (int i = 0; i < 256; i++) begin mem_m[i] = '0; mem_v[i] = 1'b0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_memwrite", {31'b0, MemWrite}, 0);
    check("rst_aluout", ALUout, 0);
    check("rst_w_rd1", W_RD1, 0);
    check("rst_w_rd2", W_RD2, 0);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) rf_write(5'(i), 16'($urandom));
    rf_write(5'd16, 16'h0033);
    rf_write(5'd17, 16'hBEEF);

    // Basic add, with latency from the accepting edge to done.
    model_op(5'd16, 5'd17, 8'h04, 4'd0, a);
    start_op(5'd16, 5'd17, 8'h04, 4'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 10);
    check("t1_done_latency", n, 3);
    check("t1_aluout", ALUout, 16'h0037);
    check_mem(8'h37);
    check("t1_mem_value", dbg_data, 16'hBEEF);
    wait_idle();

    model_op(5'd16, 5'd17, 8'hFC, 4'd0, a);
    start_op(5'd16, 5'd17, 8'hFC, 4'd0);
    wait_idle();
    check("neg_off_aluout", ALUout, 16'h002F);
    check_mem(8'h2F);

    model_op(5'd16, 5'd17, 8'h04, 4'd1, a);
    start_op(5'd16, 5'd17, 8'h04, 4'd1);
    wait_idle();
    check("sub_aluout", ALUout, 16'h002F);
    check_mem(8'h2F);

    // Address wraps into the 256-word memory.
    rf_write(5'd16, 16'h00FE);
    model_op(5'd16, 5'd17, 8'h04, 4'd0, a);
    start_op(5'd16, 5'd17, 8'h04, 4'd0);
    wait_idle();
    check("wrap_aluout", ALUout, 16'h0102);
    check_mem(8'h02);

    // R0 source reads zero; a start pulse during ADDR is ignored.
    rf_write(5'd0, 16'h1234);
    rf_write(5'd16, 16'h0040);
    d0 = done_total;
    model_op(5'd16, 5'd0, 8'h10, 4'd0, a);
    start_op(5'd16, 5'd0, 8'h10, 4'd0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("r0_store_zero", W_RD2, 16'h0000);
    check_mem(8'h50);
    check("ignored_start_one_done", done_total - d0, 1);

    // Back-to-back: next start accepted the cycle after DONE.
    rf_write(5'd18, 16'h0100);
    model_op(5'd16, 5'd17, 8'h01, 4'd0, a);
    start_op(5'd16, 5'd17, 8'h01, 4'd0);
    n = 0;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
    check("b2b_first_done", {31'b0, done}, 1);
    model_op(5'd18, 5'd19, 8'h05, 4'd0, b);
    start = 1'b1; rs = 5'd18; rt = 5'd19; offset = 8'h05; ALU_Sel = 4'd0;
    @(posedge clk); #1;
    check("b2b_idle_after_done", {31'b0, busy}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accepted", {31'b0, busy}, 1);
    wait_idle();
    check_mem(a[7:0]);
    check_mem(b[7:0]);

    // Reset during WRITE aborts the store.
    rf_write(5'd18, 16'h0030);
    rf_write(5'd20, 16'h7777);
    start_op(5'd18, 5'd20, 8'h07, 4'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!MemWrite && n < 10);
    check("abort_reached_write", {31'b0, MemWrite}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_memwrite", {31'b0, MemWrite}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_aluout", ALUout, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    check_mem(8'h37);

    // Host write to rt during READ.
    rf_write(5'd16, 16'h0060);
    rf_write(5'd17, 16'hBEEF);
`ifdef SW_BYPASS_EN
    rf_m[17] = 16'h5555;
`endif
    model_op(5'd16, 5'd17, 8'h00, 4'd0, a);
    start_op(5'd16, 5'd17, 8'h00, 4'd0);
    rf_we = 1'b1; rf_waddr = 5'd17; rf_wdata = 16'h5555;
    @(posedge clk); #1;
    rf_we = 1'b0;
    rf_m[17] = 16'h5555;
    wait_idle();
    check_mem(8'h60);

    // Randomized ops against the reference model.
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) rf_write(5'($urandom_range(0, 31)), 16'($urandom));
      r_rs  = 5'($urandom_range(0, 31));
      r_rt  = 5'($urandom_range(0, 31));
      r_off = 8'($urandom);
      r_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      model_op(r_rs, r_rt, r_off, r_sel, a);
      start_op(r_rs, r_rt, r_off, r_sel);
      wait_idle();
      check_mem(a[7:0]);
    end

    for (int i = 0; i < 256; i++) if (mem_v[i]) check_mem(8'(i));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_datapath.md
Name: sw_datapath

Overview:
- Multi-cycle store-word (SW) engine; the write-side counterpart of the LW datapath.
- Reads base register rs and source register rt from an internal 32x16 register file, then computes address = R[rs] + sign-extended offset in the ALU. Writes R[rt] into an internal 256x16 data memory.
- start/busy/done handshake; a host-side register-file write port and a memory debug read port give the bench preload and checking access.

Parameters:
- DATA_W, 16, register/memory word width
- MEM_AW, 8, data-memory address width (depth 2**MEM_AW)
- RF_AW, 5, register-file address width (32 entries)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin SW op; sampled only in IDLE
- rs  in  5  base register index
- rt  in  5  source-data register index
- offset  in  8  signed byte offset, sign-extended to DATA_W
- ALU_Sel  in  4  0000 add, 0001 sub (base - offset); other codes = add
- rf_we  in  1  host register-file write enable
- rf_waddr  in  5  host write index
- rf_wdata  in  16  host write data
- dbg_addr  in  8  memory debug read address
- dbg_data  out  16  mem[dbg_addr], combinational
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, op complete
- MemWrite  out  1  high during WRITE state only
- ALUout  out  16  registered effective address/ALU result
- W_RD1  out  16  latched R[rs]
- W_RD2  out  16  latched R[rt]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, MemWrite=0; ALUout, W_RD1, W_RD2=0. Register file and memory arrays are not cleared. R0 always reads 0.
- FSM: IDLE -> READ -> ADDR -> WRITE -> DONE -> IDLE.
  - IDLE: start=1 at edge E0 latches rs, rt, offset, ALU_Sel -> READ.
  - READ: edge E1 latches W_RD1=R[rs], W_RD2=R[rt] -> ADDR.
  - ADDR: edge E2 latches ALUout = W_RD1 +/- sext(offset), mod 2^16 -> WRITE.
  - WRITE: MemWrite=1; edge E3 writes mem[ALUout[7:0]] <= W_RD2 -> DONE.
  - DONE: done=1 for this cycle only; edge E4 -> IDLE.
- Latency: memory updated at the 3rd edge after start is sampled; done visible in the following cycle. Back-to-back: a new start is accepted in IDLE the cycle after DONE (5-cycle op period).
- start while busy: ignored, not queued. Operand inputs are don't-care after E0.
- Address wrap: ALU result is full 16-bit with wrap. Memory index is ALUout[7:0]; e.g. 0x00FE+4 -> 0x0102 -> mem[0x02].
- Register-file host write: synchronous on clk when rf_we=1. Writes to R0 are ignored. Allowed in any state.
- Simultaneous rf_we to rs/rt on edge E1: W_RD1/W_RD2 capture the old value (no bypass).
- Reset mid-operation: asserting rst_n=0 before E3 aborts with no memory write. Asserting it in DONE leaves the completed write intact.
- dbg_data reflects a write from the cycle after E3.

Optional Feature:
- Macro: SW_BYPASS_EN
- Defined: in READ, if rf_we=1 and rf_waddr equals a nonzero latched rs or rt, the corresponding W_RD1/W_RD2 captures rf_wdata (write-through forward).
- Undefined: old register value captured, as specified above.

Test Plan:
- Preload R16=0x0033, R17=0xBEEF; start rs=16 rt=17 offset=0x04 add -> ALUout=0x0037, MemWrite pulse one cycle, mem[0x37]=0xBEEF, done pulse 4 cycles after start.
- Same regs, offset=0xFC (-4), add -> ALUout=0x002F, mem[0x2F]=0xBEEF. ALU_Sel=0001 offset=0x04 -> ALUout=0x002F.
- R16=0x00FE, offset=0x04 -> ALUout=0x0102, mem[0x02] written; mem[0x102] aliasing confirmed via dbg_addr=0x02.
- rt=0 after host write of 0x1234 to R0 -> mem[addr]=0x0000. Pulse start again during ADDR -> ignored, exactly one done.
- rst_n low during WRITE state before edge E3 -> busy/MemWrite/done=0 asynchronously, target memory word unchanged.
- rf_we to R17=0x5555 in READ cycle -> mem gets 0xBEEF without SW_BYPASS_EN, 0x5555 with it.
